// File: rtl/life_grid_engine.sv
// Conway's Life board engine: clears, edits and evolves an ROWS x COLS board driven by game_state.
// Define LIFE_TORUS_EN for a toroidal board; otherwise out-of-board neighbours are dead.
module life_grid_engine #(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned GEN_W    = 16
) (
  input  logic                            clka,
  input  logic                            rst_n,
  input  logic [1:0]                      game_state,
  input  logic                            btn0,
  input  logic                            btn1,
  output logic [ROWS*COLS-1:0]            grid,
  output logic [$clog2(ROWS*COLS)-1:0]    cursor,
  output logic [GEN_W-1:0]                gen_count,
  output logic                            busy
);

  localparam int unsigned N   = ROWS * COLS;
  localparam int unsigned CW  = $clog2(N);
  localparam int unsigned TW  = $clog2(TICK_DIV);
  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CCW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [1:0] GsIdle    = 2'b00;
  localparam logic [1:0] GsProgram = 2'b01;
  localparam logic [1:0] GsRun     = 2'b10;
  localparam logic [1:0] GsPause   = 2'b11;

  typedef enum logic [2:0] {
    StClear,
    StEdit,
    StWait,
    StScan,
    StCommit,
    StHold
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grid_q, grid_d;
  logic [N-1:0]     next_q, next_d;
  logic [CW-1:0]    cursor_q, cursor_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             busy_q, busy_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CCW-1:0]   col_q, col_d;
  logic             btn0_q, btn1_q;

  logic             btn0_edge, btn1_edge;
  logic [CW-1:0]    scan_idx;
  logic [3:0]       nbr_cnt;
  logic             next_bit;
  logic             scan_last;

  assign btn0_edge = btn0 & ~btn0_q;
  assign btn1_edge = btn1 & ~btn1_q;
  assign scan_idx  = CW'(int'(row_q) * int'(COLS) + int'(col_q));
  assign scan_last = (row_q == RW'(ROWS - 1)) && (col_q == CCW'(COLS - 1));

  // Neighbour count is always taken from the committed board, never the shadow buffer.
  always_comb begin : nbr_count
    int r;
    int c;
    logic [CW-1:0] nidx;
    r       = 0;
    c       = 0;
    nidx    = '0;
    nbr_cnt = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        r = int'(row_q) + dr;
        c = int'(col_q) + dc;
`ifdef LIFE_TORUS_EN
        if (r < 0) r = int'(ROWS) - 1;
        else if (r >= int'(ROWS)) r = 0;
        if (c < 0) c = int'(COLS) - 1;
        else if (c >= int'(COLS)) c = 0;
        if (!(dr == 0 && dc == 0)) begin
          nidx    = CW'(r * int'(COLS) + c);
          nbr_cnt = nbr_cnt + 4'(grid_q[nidx]);
        end
`else
        if (!(dr == 0 && dc == 0) && r >= 0 && r < int'(ROWS) && c >= 0 && c < int'(COLS)) begin
          nidx    = CW'(r * int'(COLS) + c);
          nbr_cnt = nbr_cnt + 4'(grid_q[nidx]);
        end
`endif
      end
    end
  end

  assign next_bit = (nbr_cnt == 4'd3) | (grid_q[scan_idx] & (nbr_cnt == 4'd2));

  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    next_d   = next_q;
    cursor_d = cursor_q;
    gen_d    = gen_q;
    tick_d   = tick_q;
    busy_d   = busy_q;
    row_d    = row_q;
    col_d    = col_q;
    unique case (game_state)
      GsIdle: begin
        state_d  = StClear;
        grid_d   = '0;
        cursor_d = '0;
        gen_d    = '0;
        tick_d   = '0;
        busy_d   = 1'b0;
      end
      GsProgram: begin
        // Entering edit aborts any pass; the shadow buffer is simply never committed.
        state_d = StEdit;
        busy_d  = 1'b0;
        if (btn1_edge) grid_d[cursor_q] = ~grid_q[cursor_q];
        if (btn0_edge) cursor_d = (cursor_q == CW'(N - 1)) ? '0 : cursor_q + 1'b1;
      end
      GsRun, GsPause: begin
        case (state_q)
          StScan: begin
            next_d[scan_idx] = next_bit;
            if (scan_last) begin
              state_d = StCommit;
            end else if (col_q == CCW'(COLS - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
          StCommit: begin
            grid_d  = next_q;
            gen_d   = gen_q + 1'b1;
            busy_d  = 1'b0;
            state_d = (game_state == GsRun) ? StWait : StHold;
          end
          default: begin
            if (game_state == GsRun) begin
              if (tick_q == TW'(TICK_DIV - 1)) begin
                tick_d  = '0;
                row_d   = '0;
                col_d   = '0;
                busy_d  = 1'b1;
                state_d = StScan;
              end else begin
                tick_d  = tick_q + 1'b1;
                state_d = StWait;
              end
            end else begin
              state_d = StHold;
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StClear;
      grid_q   <= '0;
      next_q   <= '0;
      cursor_q <= '0;
      gen_q    <= '0;
      tick_q   <= '0;
      busy_q   <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      btn0_q   <= 1'b0;
      btn1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      next_q   <= next_d;
      cursor_q <= cursor_d;
      gen_q    <= gen_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      row_q    <= row_d;
      col_q    <= col_d;
      btn0_q   <= btn0;
      btn1_q   <= btn1;
    end
  end

  assign grid      = grid_q;
  assign cursor    = cursor_q;
  assign gen_count = gen_q;
  assign busy      = busy_q;

endmodule
